uart_rx_fsm_param: RTL and testbench
====================================

Name: uart_rx_fsm_param

Overview:
Parametrised UART receive engine. It combines the receive control FSM, the oversampling bit-timing counter, the deserialiser and an output holding register with a valid/ready handshake. It sits between the rx pin and the LSU-facing receive data path, and supports configurable data width, parity mode, stop-bit count and oversampling ratio.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, baud_tick pulses per bit period; even value, >=4.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
baud_tick  in  1  single-cycle oversample strobe, OVERSAMPLE per bit.
rx_in  in  1  asynchronous serial line; idle high.
rx_ready  in  1  consumer accepts rx_data when rx_valid=1.
rx_data  out  DATA_BITS  received word, LSB = first bit on line.
rx_valid  out  1  holding register contains an unconsumed word.
parity_err  out  1  parity mismatch for the word in rx_data; qualified by rx_valid.
frame_err  out  1  a stop bit sampled 0 for the word in rx_data; qualified by rx_valid.
overrun_err  out  1  one-cycle pulse: completed frame dropped because the holding register was full.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, rx_data 0, FSM to IDLE, synchroniser flops 1, counters 0. Reset mid-frame abandons the frame with no flags raised.
- rx_in passes through a 2-flop synchroniser to produce rx_s. All FSM decisions use rx_s and advance only on cycles where baud_tick=1.
- Tick counter tcnt: width clog2(OVERSAMPLE). Bit counter bcnt: width clog2(DATA_BITS+1).
- IDLE -> START: on a tick with rx_s=0. tcnt cleared.
- START: counts ticks. On the tick where tcnt = OVERSAMPLE/2-1 (start-bit midpoint):
  - rx_s=1 -> false start, go to IDLE.
  - rx_s=0 -> go to DATA; tcnt and bcnt cleared.
- DATA: on the tick where tcnt = OVERSAMPLE-1:
  - sample rx_s into the shift register, filling from the MSB and shifting right, so LSB-first framing holds;
  - bcnt increments;
  - after the DATA_BITS-th sample, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: sample at the full-period point. Compute parity_calc = XOR of the data bits, inverted for odd mode; perr = sampled bit != parity_calc. Then go to STOP.
- STOP: sample STOP_BITS bits at full-period points. ferr is set if any stop sample is 0. After the last sample, go to STORE.
  - The FSM does not wait for the line to return high. A new start is searched for from IDLE on the next tick.
- STORE: lasts exactly one clk cycle, then returns to IDLE.
  - Holding register empty (rx_valid=0), or being drained this cycle (rx_valid & rx_ready): rx_data <= shift register, parity_err <= perr, frame_err <= ferr, rx_valid <= 1.
  - Otherwise: the frame is dropped, rx_data and flags are unchanged, and overrun_err pulses for 1 cycle.
- Latency: rx_valid rises 2 clk cycles after the tick that samples the last stop bit (1 cycle into STORE, 1 cycle to register).
- Handshake: rx_valid & rx_ready transfers the word. rx_valid then clears next cycle unless STORE reloads in the same cycle, in which case it stays 1 with the new word.
  - rx_data, parity_err and frame_err hold stable while rx_valid=1 and rx_ready=0.
- Frames with frame or parity errors are still stored, with their flags set.
- busy = (state != IDLE).

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: adds output port break_det (1 bit, reset 0). When a frame reaches STORE with every data bit, the parity bit (if present) and every stop bit sampled 0:
  - break_det pulses for 1 cycle;
  - the frame is not stored and rx_valid is unaffected;
  - the FSM enters a BREAK state and returns to IDLE only after a tick with rx_s=1.
- Undefined: no break_det port and no BREAK state. An all-zero frame is stored as data 0 with frame_err=1.

Test Plan:
- 8N1, OVERSAMPLE=16, rx_ready=1: send 0xA5 with a correct stop bit -> rx_valid pulses once, rx_data=0xA5, parity_err=0, frame_err=0.
- Glitch: rx_in low for 4 ticks, then high -> FSM returns to IDLE at the midpoint check, busy drops, rx_valid stays 0.
- PARITY_MODE=1: send 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1. Same data with parity bit 1 -> parity_err=0.
- Stop bit driven 0 on 0x3C -> rx_data=0x3C, frame_err=1. With STOP_BITS=2 and only the second stop bit 0 -> frame_err=1.
- rx_ready=0: send 0x11 then 0x22 -> overrun_err pulses 1 cycle at the second STORE, rx_data remains 0x11. Raise rx_ready -> transfer completes, then rx_valid=0.
- Reset asserted mid-DATA of 0x55 -> all outputs 0 and busy=0 next cycle. A following 0x0F is received correctly. With UART_RX_BREAK_DETECT_EN defined, a 12-bit-time low line -> break_det pulses once and rx_valid stays 0.

Source files
------------

// File: rtl/uart_rx_fsm_param_if.sv
// Receive-side holding-register interface: word, error flags and the valid/ready pair.
// valid/ready: a word transfers on every clk edge where rx_valid & rx_ready; rx_data and flags stay stable while rx_valid=1 and rx_ready=0.
interface uart_rx_fsm_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fsm_param.sv
// Parametrised UART receiver: synchroniser, oversampled bit timing, deserialiser, holding register.
// Optional macro UART_RX_BREAK_DETECT_EN adds break_det and a BREAK state for all-zero frames.
module uart_rx_fsm_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       baud_tick,
    input  logic                       rx_in,
    uart_rx_fsm_param_if.master        rx_bus,
    output logic                       overrun_err,
    output logic                       busy,
    output logic [2:0]                 state_dbg
`ifdef UART_RX_BREAK_DETECT_EN
    , output logic                     break_det
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STORE  = 3'd5
`ifdef UART_RX_BREAK_DETECT_EN
        , S_BREAK = 3'd6
`endif
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_sync1_q, rx_s_q;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 full_tick;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 zero_q, zero_d;
    logic                 break_q, break_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q   <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q       <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            rx_sync1_q   <= rx_in;
            rx_s_q       <= rx_sync1_q;
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q       <= zero_d;
            break_q      <= break_d;
`endif
        end
    end

    assign full_tick = baud_tick && (tcnt_q == T_FULL);

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d       = zero_q;
        break_d      = 1'b0;
`endif
        if (rx_valid_q && rx_bus.rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (baud_tick && !rx_s_q) begin
                    state_d = S_START;
                    tcnt_d  = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (tcnt_q == T_MID) begin
                        // Midpoint of the start bit: a high line here was a glitch.
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_d  = 1'b1;
`endif
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    tcnt_d  = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d  = zero_q & ~rx_s_q;
`endif
                    if (bcnt_q == B_LAST) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else if (baud_tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (full_tick) begin
                    tcnt_d  = '0;
                    perr_d  = rx_s_q ^ (^shreg_q) ^ PAR_ODD;
                    state_d = S_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d  = zero_q & ~rx_s_q;
`endif
                end else if (baud_tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (full_tick) begin
                    tcnt_d = '0;
                    if (!rx_s_q) ferr_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~rx_s_q;
`endif
                    if (bcnt_q == S_LAST) begin
                        state_d = S_STORE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else if (baud_tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_STORE: begin
                state_d = S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                if (zero_q) begin
                    break_d = 1'b1;
                    state_d = S_BREAK;
                end else
`endif
                // Load when empty or when the current word is being drained this cycle.
                if (!rx_valid_q || rx_bus.rx_ready) begin
                    rx_data_d    = shreg_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ferr_q;
                    rx_valid_d   = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            S_BREAK: begin
                if (baud_tick && rx_s_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_bus.rx_data    = rx_data_q;
    assign rx_bus.rx_valid   = rx_valid_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign overrun_err       = overrun_q;
    assign busy              = (state_q != S_IDLE);
    assign state_dbg         = state_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det         = break_q;
`endif
endmodule

// File: tb/tb_uart_rx_fsm_param.sv
// Directed bench: an 8N1/OS16 receiver and an 8E2/OS8 receiver share clock, reset and baud_tick.
module tb_uart_rx_fsm_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       ov_a, busy_a, ov_b, busy_b;
    logic [2:0] st_a, st_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_a, brk_b;
`endif

    uart_rx_fsm_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_fsm_param_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_fsm_param dut_a (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_a),
        .rx_bus(bus_a.master), .overrun_err(ov_a), .busy(busy_a), .state_dbg(st_a)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_a)
`endif
    );

    uart_rx_fsm_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_b),
        .rx_bus(bus_b.master), .overrun_err(ov_b), .busy(busy_b), .state_dbg(st_b)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_b)
`endif
    );

    // clock / reset / tick
    initial forever #5 clk = ~clk;

    int tick_ctr = 0;
    initial forever begin
        @(negedge clk);
        tick_ctr++;
        baud_tick = tick_ctr[0];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int         checks = 0;
    int         failures = 0;
    int         ov_cnt_a = 0;
    int         brk_cnt_a = 0;
    logic [9:0] got_a[$];
    logic [9:0] got_b[$];
    logic [9:0] exp_q[$];

    initial forever begin
        @(negedge clk);
        if (bus_a.rx_valid && bus_a.rx_ready)
            got_a.push_back({bus_a.rx_data, bus_a.parity_err, bus_a.frame_err});
        if (bus_b.rx_valid && bus_b.rx_ready)
            got_b.push_back({bus_b.rx_data, bus_b.parity_err, bus_b.frame_err});
        if (ov_a) ov_cnt_a++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_a) brk_cnt_a++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input int sel, input logic v);
        @(negedge clk);
        if (sel == 0) rx_a = v; else rx_b = v;
        wait_ticks((sel == 0) ? 16 : 8);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic par,
                              input logic s1, input logic s2);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, data[i]);
        if (sel == 1) send_bit(sel, par);
        send_bit(sel, s1);
        if (sel == 1) send_bit(sel, s2);
        send_bit(sel, 1'b1);
        send_bit(sel, 1'b1);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [9:0] e, g;
        int         n;

        // sel, data, parity bit, stop1, stop2, expected data, perr, ferr
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[7] = '{1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[8] = '{1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[9] = '{1, 8'hFE, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0};

        bus_a.rx_ready = 1'b1;
        bus_b.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid_a", {31'd0, bus_a.rx_valid}, 32'd0);
        check("reset_data_a", {24'd0, bus_a.rx_data}, 32'd0);
        check("reset_flags_a", {29'd0, bus_a.parity_err, bus_a.frame_err, ov_a}, 32'd0);
        check("reset_busy_a", {31'd0, busy_a}, 32'd0);
        check("reset_state_b", {29'd0, st_b}, 32'd0);
        reset = 1'b0;
        wait_ticks(4);

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2);
            n = (vecs[i].sel == 0) ? got_a.size() : got_b.size();
            check($sformatf("vec%0d_count", i), n, 32'd1);
            e = exp_q.pop_front();
            g = 10'bx;
            if (vecs[i].sel == 0 && got_a.size() > 0) g = got_a.pop_front();
            if (vecs[i].sel == 1 && got_b.size() > 0) g = got_b.pop_front();
            check($sformatf("vec%0d_word", i), {22'd0, g}, {22'd0, e});
            got_a.delete();
            got_b.delete();
        end

        // glitch: low for 4 ticks, then high before the midpoint
        @(negedge clk);
        rx_a = 1'b0;
        wait_ticks(4);
        check("glitch_busy_high", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        rx_a = 1'b1;
        wait_ticks(12);
        check("glitch_busy_low", {31'd0, busy_a}, 32'd0);
        check("glitch_no_word", got_a.size(), 32'd0);

        // overrun: two frames with the consumer stalled
        @(negedge clk);
        bus_a.rx_ready = 1'b0;
        ov_cnt_a = 0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        check("ovr_first_valid", {31'd0, bus_a.rx_valid}, 32'd1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        check("ovr_pulse_count", ov_cnt_a, 32'd1);
        check("ovr_valid_held", {31'd0, bus_a.rx_valid}, 32'd1);
        check("ovr_data_held", {24'd0, bus_a.rx_data}, 32'h11);
        check("ovr_nothing_taken", got_a.size(), 32'd0);
        @(posedge clk);
        #1 bus_a.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_drain_count", got_a.size(), 32'd1);
        g = (got_a.size() > 0) ? got_a.pop_front() : 10'bx;
        check("ovr_drain_word", {22'd0, g}, {22'd0, 8'h11, 2'b00});
        check("ovr_valid_clear", {31'd0, bus_a.rx_valid}, 32'd0);
        got_a.delete();

        // reset in the middle of the data bits of 0x55
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        rx_a = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_data", {24'd0, bus_a.rx_data}, 32'd0);
        check("midrst_valid", {31'd0, bus_a.rx_valid}, 32'd0);
        check("midrst_state", {29'd0, st_a}, 32'd0);
        reset = 1'b0;
        wait_ticks(4);
        got_a.delete();
        exp_q.push_back({8'h0F, 2'b00});
        send_frame(0, 8'h0F, 1'b0, 1'b1, 1'b1);
        check("after_rst_count", got_a.size(), 32'd1);
        e = exp_q.pop_front();
        g = (got_a.size() > 0) ? got_a.pop_front() : 10'bx;
        check("after_rst_word", {22'd0, g}, {22'd0, e});
        got_a.delete();

`ifdef UART_RX_BREAK_DETECT_EN
        // line held low for 12 bit times
        brk_cnt_a = 0;
        @(negedge clk);
        rx_a = 1'b0;
        wait_ticks(12 * 16);
        check("brk_pulse_count", brk_cnt_a, 32'd1);
        check("brk_busy_held", {31'd0, busy_a}, 32'd1);
        check("brk_no_valid", {31'd0, bus_a.rx_valid}, 32'd0);
        @(negedge clk);
        rx_a = 1'b1;
        wait_ticks(8);
        check("brk_release_busy", {31'd0, busy_a}, 32'd0);
        check("brk_no_word", got_a.size(), 32'd0);
`else
        // all-zero frame is a plain word with a framing error
        exp_q.push_back({8'h00, 2'b01});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("zero_frame_count", got_a.size(), 32'd1);
        e = exp_q.pop_front();
        g = (got_a.size() > 0) ? got_a.pop_front() : 10'bx;
        check("zero_frame_word", {22'd0, g}, {22'd0, e});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
